// File: rtl/cbc_command_issuer_pkg.sv
// Shared constants for the CBC command issuer: bus geometry, field positions,
// reserved VPID, idle word, request modes, VP operation codes and FSM states.
package cbc_command_issuer_pkg;

    localparam int CBC_W  = 32;
    localparam int VPID_W = 4;
    localparam int OP_W   = 4;
    localparam int DATA_W = CBC_W - 1 - VPID_W - OP_W;

    localparam int BCAST_BIT = CBC_W - 1;
    localparam int DATA_MSB  = CBC_W - 2;
    localparam int DATA_LSB  = VPID_W + OP_W;
    localparam int OP_MSB    = VPID_W + OP_W - 1;
    localparam int OP_LSB    = VPID_W;
    localparam int DST_MSB   = VPID_W - 1;
    localparam int DST_LSB   = 0;

    // All-ones VPID is never assigned to a VP, so the idle word matches nobody.
    localparam logic [VPID_W-1:0] VPID_NONE     = '1;
    localparam logic [CBC_W-1:0]  CBC_IDLE_WORD = {{(CBC_W - VPID_W){1'b0}}, VPID_NONE};

    typedef enum logic [1:0] {
        MODE_UNICAST = 2'd0,
        MODE_BCAST   = 2'd1,
        MODE_SWEEP   = 2'd2,
        MODE_RSVD    = 2'd3
    } req_mode_e;

    typedef enum logic [OP_W-1:0] {
        OP_NOP               = 4'd0,
        OP_START_MAIN_THREAD = 4'd1,
        OP_STOP_MAIN_THREAD  = 4'd2
    } vp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/cbc_word_pack.sv
// Combinational packer: assembles one CBC bus word from broadcast flag,
// operation, destination and payload.
module cbc_word_pack
    import cbc_command_issuer_pkg::*;
(
    input  logic              bcast_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [VPID_W-1:0] dst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CBC_W-1:0]  word_o
);

    always_comb begin
        word_o                    = '0;
        word_o[BCAST_BIT]         = bcast_i;
        word_o[DATA_MSB:DATA_LSB] = data_i;
        word_o[OP_MSB:OP_LSB]     = op_i;
        word_o[DST_MSB:DST_LSB]   = dst_i;
    end

endmodule

// File: rtl/cbc_command_issuer.sv
// Issues unicast/broadcast/sweep commands onto the CBC bus, one word per target,
// throttled by VP busy. Define CBC_ISSUE_COUNTER_EN to build the issued-word counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request, bus idle
// ST_ISSUE | loading one word per target, idle word while VP busy
// ST_DONE  | last word on bus; next edge pulses oDone and returns idle
// ST_ERR   | rejected request; next edge pulses oReqErr and returns idle
module cbc_command_issuer
    import cbc_command_issuer_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic [1:0]        iReqMode,
    input  logic [OP_W-1:0]   iReqOp,
    input  logic [VPID_W-1:0] iReqDstLo,
    input  logic [VPID_W-1:0] iReqDstHi,
    input  logic [DATA_W-1:0] iReqData,
    input  logic              iVpBusy,
    output logic [CBC_W-1:0]  oCpCommand,
    output logic              oDone,
    output logic              oReqErr,
    output logic [15:0]       oIssueCount
);

    issuer_state_e     state_q;
    req_mode_e         mode_q;
    logic [OP_W-1:0]   op_q;
    logic [VPID_W-1:0] hi_q;
    logic [VPID_W-1:0] tgt_q;
    logic [DATA_W-1:0] data_q;
    logic [CBC_W-1:0]  cmd_q;
    logic              done_q;
    logic              err_q;

    logic              req_bad;
    logic              is_bcast;
    logic              last_word;
    logic [VPID_W-1:0] word_dst;
    logic [CBC_W-1:0]  issue_word;

    always_comb begin
        req_bad = 1'b0;
        if (iReqMode == MODE_RSVD) begin
            req_bad = 1'b1;
        end else if (iReqMode != MODE_BCAST && iReqDstLo == VPID_NONE) begin
            req_bad = 1'b1;
        end else if (iReqMode == MODE_SWEEP &&
                     (iReqDstLo > iReqDstHi || iReqDstHi == VPID_NONE)) begin
            req_bad = 1'b1;
        end
    end

    assign is_bcast  = (mode_q == MODE_BCAST);
    assign last_word = (mode_q != MODE_SWEEP) || (tgt_q == hi_q);
    assign word_dst  = is_bcast ? VPID_NONE : tgt_q;

    cbc_word_pack u_pack (
        .bcast_i (is_bcast),
        .op_i    (op_q),
        .dst_i   (word_dst),
        .data_i  (data_q),
        .word_o  (issue_word)
    );

    // Ready is a pure state decode, held low for as long as reset is applied.
    assign oReqReady  = (state_q == ST_IDLE) && !Reset;
    assign oCpCommand = cmd_q;
    assign oDone      = done_q;
    assign oReqErr    = err_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_UNICAST;
            op_q    <= '0;
            hi_q    <= '0;
            tgt_q   <= '0;
            data_q  <= '0;
            cmd_q   <= CBC_IDLE_WORD;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_q <= CBC_IDLE_WORD;
                    if (iReqValid) begin
                        mode_q  <= req_mode_e'(iReqMode);
                        op_q    <= iReqOp;
                        tgt_q   <= iReqDstLo;
                        hi_q    <= iReqDstHi;
                        data_q  <= iReqData;
                        state_q <= req_bad ? ST_ERR : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (iVpBusy) begin
                        cmd_q <= CBC_IDLE_WORD;
                    end else begin
                        cmd_q <= issue_word;
                        if (last_word) begin
                            state_q <= ST_DONE;
                        end else begin
                            tgt_q <= tgt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    cmd_q   <= CBC_IDLE_WORD;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    cmd_q   <= CBC_IDLE_WORD;
                    err_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cmd_q   <= CBC_IDLE_WORD;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CBC_ISSUE_COUNTER_EN
    logic [15:0] issue_cnt_q;
    logic        word_load;

    assign word_load   = (state_q == ST_ISSUE) && !iVpBusy;
    assign oIssueCount = issue_cnt_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            issue_cnt_q <= '0;
        end else if (word_load && issue_cnt_q != 16'hFFFF) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end
`else
    assign oIssueCount = '0;
`endif

endmodule

// File: tb/tb_cbc_command_issuer.sv
// Directed self-checking bench for cbc_command_issuer: unicast, broadcast,
// stalled sweep, rejected requests, mid-sweep reset and back-to-back requests.
module tb_cbc_command_issuer;

    localparam logic [31:0] IDLE_W = 32'h0000000F;
`ifdef CBC_ISSUE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iReqValid;
    logic        oReqReady;
    logic [1:0]  iReqMode;
    logic [3:0]  iReqOp;
    logic [3:0]  iReqDstLo;
    logic [3:0]  iReqDstHi;
    logic [22:0] iReqData;
    logic        iVpBusy;
    logic [31:0] oCpCommand;
    logic        oDone;
    logic        oReqErr;
    logic [15:0] oIssueCount;

    int checks = 0;
    int errors = 0;

    cbc_command_issuer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iReqValid   (iReqValid),
        .oReqReady   (oReqReady),
        .iReqMode    (iReqMode),
        .iReqOp      (iReqOp),
        .iReqDstLo   (iReqDstLo),
        .iReqDstHi   (iReqDstHi),
        .iReqData    (iReqData),
        .iVpBusy     (iVpBusy),
        .oCpCommand  (oCpCommand),
        .oDone       (oDone),
        .oReqErr     (oReqErr),
        .oIssueCount (oIssueCount)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input logic [1:0] mode, input logic [3:0] op,
                           input logic [3:0] lo, input logic [3:0] hi,
                           input logic [22:0] data);
        iReqValid = 1'b1;
        iReqMode  = mode;
        iReqOp    = op;
        iReqDstLo = lo;
        iReqDstHi = hi;
        iReqData  = data;
    endtask

    task automatic test_reset();
        checks++; if (oCpCommand !== IDLE_W) begin errors++; $display("FAIL rst_cmd got %h exp %h", oCpCommand, IDLE_W); end
        checks++; if (oReqReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", oReqReady); end
        checks++; if (oDone !== 1'b0 || oReqErr !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%b err=%b exp 0/0", oDone, oReqErr); end
        checks++; if (oIssueCount !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", oIssueCount); end
        Reset = 1'b0;
        #1;
        checks++; if (oReqReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", oReqReady); end
    endtask

    task automatic test_unicast();
        set_req(2'd0, 4'd1, 4'd3, 4'd0, 23'h5A);
        step();
        iReqValid = 1'b0;
        checks++; if (oCpCommand !== IDLE_W || oReqReady !== 1'b0) begin errors++; $display("FAIL uni_accept got cmd=%h rdy=%b exp %h/0", oCpCommand, oReqReady, IDLE_W); end
        step();
        checks++; if (oCpCommand !== 32'h00005A13 || oDone !== 1'b0) begin errors++; $display("FAIL uni_word got %h done=%b exp 00005a13/0", oCpCommand, oDone); end
        step();
        checks++; if (oCpCommand !== IDLE_W || oDone !== 1'b1 || oReqReady !== 1'b1) begin errors++; $display("FAIL uni_done got cmd=%h done=%b rdy=%b exp %h/1/1", oCpCommand, oDone, oReqReady, IDLE_W); end
        step();
        checks++; if (oDone !== 1'b0 || oCpCommand !== IDLE_W) begin errors++; $display("FAIL uni_after got cmd=%h done=%b exp %h/0", oCpCommand, oDone, IDLE_W); end
    endtask

    task automatic test_broadcast();
        logic [15:0] exp_cnt;
        exp_cnt = CNT_EN ? 16'd2 : 16'd0;
        set_req(2'd1, 4'd2, 4'd0, 4'd0, 23'h0);
        step();
        iReqValid = 1'b0;
        step();
        checks++; if (oCpCommand !== 32'h8000002F) begin errors++; $display("FAIL bc_word got %h exp 8000002f", oCpCommand); end
        step();
        checks++; if (oCpCommand !== IDLE_W || oDone !== 1'b1) begin errors++; $display("FAIL bc_done got cmd=%h done=%b exp %h/1", oCpCommand, oDone, IDLE_W); end
        checks++; if (oIssueCount !== exp_cnt) begin errors++; $display("FAIL bc_count got %0d exp %0d", oIssueCount, exp_cnt); end
        step();
    endtask

    task automatic test_sweep_stall();
        logic [31:0] exp_seq [6];
        exp_seq = '{32'h00001112, 32'h00001113, IDLE_W, IDLE_W, 32'h00001114, 32'h00001115};
        set_req(2'd2, 4'd1, 4'd2, 4'd5, 23'h11);
        step();
        iReqValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (oCpCommand !== exp_seq[i] || oDone !== 1'b0) begin errors++; $display("FAIL sweep_word[%0d] got %h done=%b exp %h/0", i, oCpCommand, oDone, exp_seq[i]); end
            if (i == 1) iVpBusy = 1'b1;
            if (i == 3) iVpBusy = 1'b0;
        end
        step();
        checks++; if (oCpCommand !== IDLE_W || oDone !== 1'b1) begin errors++; $display("FAIL sweep_done got cmd=%h done=%b exp %h/1", oCpCommand, oDone, IDLE_W); end
        step();
    endtask

    task automatic test_invalid();
        logic [1:0] modes [3];
        logic [3:0] los   [3];
        logic [3:0] his   [3];
        modes = '{2'd2, 2'd0, 2'd3};
        los   = '{4'd6, 4'hF, 4'd1};
        his   = '{4'd4, 4'd0, 4'd2};
        for (int i = 0; i < 3; i++) begin
            set_req(modes[i], 4'd1, los[i], his[i], 23'h7);
            step();
            iReqValid = 1'b0;
            checks++; if (oCpCommand !== IDLE_W || oReqReady !== 1'b0 || oReqErr !== 1'b0) begin errors++; $display("FAIL inv_accept[%0d] got cmd=%h rdy=%b err=%b exp %h/0/0", i, oCpCommand, oReqReady, oReqErr, IDLE_W); end
            step();
            checks++; if (oReqErr !== 1'b1 || oReqReady !== 1'b1 || oCpCommand !== IDLE_W || oDone !== 1'b0) begin errors++; $display("FAIL inv_err[%0d] got err=%b rdy=%b cmd=%h done=%b exp 1/1/%h/0", i, oReqErr, oReqReady, oCpCommand, oDone, IDLE_W); end
            step();
            checks++; if (oReqErr !== 1'b0) begin errors++; $display("FAIL inv_clear[%0d] got %b exp 0", i, oReqErr); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [15:0] exp_cnt;
        set_req(2'd2, 4'd1, 4'd0, 4'd9, 23'h0);
        step();
        iReqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (oCpCommand !== 32'h00000010 + i) begin errors++; $display("FAIL rsw_word[%0d] got %h exp %h", i, oCpCommand, 32'h00000010 + i); end
        end
        #2 Reset = 1'b1;
        #1;
        checks++; if (oCpCommand !== IDLE_W || oReqReady !== 1'b0) begin errors++; $display("FAIL rsw_async got cmd=%h rdy=%b exp %h/0", oCpCommand, oReqReady, IDLE_W); end
        step();
        step();
        Reset = 1'b0;
        step();
        checks++; if (oDone !== 1'b0 || oReqReady !== 1'b1 || oCpCommand !== IDLE_W || oIssueCount !== 16'd0) begin errors++; $display("FAIL rsw_after got done=%b rdy=%b cmd=%h cnt=%0d exp 0/1/%h/0", oDone, oReqReady, oCpCommand, oIssueCount, IDLE_W); end
        set_req(2'd0, 4'd3, 4'd7, 4'd0, 23'h1);
        step();
        iReqValid = 1'b0;
        step();
        checks++; if (oCpCommand !== 32'h00000137) begin errors++; $display("FAIL rsw_uni got %h exp 00000137", oCpCommand); end
        step();
        exp_cnt = CNT_EN ? 16'd1 : 16'd0;
        checks++; if (oDone !== 1'b1 || oIssueCount !== exp_cnt) begin errors++; $display("FAIL rsw_uni_done got done=%b cnt=%0d exp 1/%0d", oDone, oIssueCount, exp_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_cnt;
        set_req(2'd0, 4'd1, 4'd1, 4'd0, 23'h2);
        step();
        set_req(2'd0, 4'd1, 4'd2, 4'd0, 23'h3);
        checks++; if (oReqReady !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got %b exp 0", oReqReady); end
        step();
        checks++; if (oCpCommand !== 32'h00000211 || oReqReady !== 1'b0) begin errors++; $display("FAIL b2b_first got %h rdy=%b exp 00000211/0", oCpCommand, oReqReady); end
        step();
        checks++; if (oCpCommand !== IDLE_W || oDone !== 1'b1 || oReqReady !== 1'b1) begin errors++; $display("FAIL b2b_done1 got cmd=%h done=%b rdy=%b exp %h/1/1", oCpCommand, oDone, oReqReady, IDLE_W); end
        step();
        iReqValid = 1'b0;
        checks++; if (oCpCommand !== IDLE_W || oDone !== 1'b0 || oReqReady !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got cmd=%h done=%b rdy=%b exp %h/0/0", oCpCommand, oDone, oReqReady, IDLE_W); end
        step();
        checks++; if (oCpCommand !== 32'h00000312) begin errors++; $display("FAIL b2b_second got %h exp 00000312", oCpCommand); end
        step();
        exp_cnt = CNT_EN ? 16'd3 : 16'd0;
        checks++; if (oCpCommand !== IDLE_W || oDone !== 1'b1 || oIssueCount !== exp_cnt) begin errors++; $display("FAIL b2b_done2 got cmd=%h done=%b cnt=%0d exp %h/1/%0d", oCpCommand, oDone, oIssueCount, IDLE_W, exp_cnt); end
        step();
        checks++; if (oCpCommand !== IDLE_W || oReqReady !== 1'b1) begin errors++; $display("FAIL b2b_idle got cmd=%h rdy=%b exp %h/1", oCpCommand, oReqReady, IDLE_W); end
    endtask

    initial begin
        Reset     = 1'b1;
        iReqValid = 1'b0;
        iReqMode  = 2'd0;
        iReqOp    = 4'd0;
        iReqDstLo = 4'd0;
        iReqDstHi = 4'd0;
        iReqData  = 23'd0;
        iVpBusy   = 1'b0;
        step();
        step();
        test_reset();
        step();
        test_unicast();
        test_broadcast();
        test_sweep_stall();
        test_invalid();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
